slot_arbiter_dc: RTL and testbench
==================================

// Module: slot_arbiter_dc
// PURPOSE
//  Time-slot round-robin arbiter that shares one 2-bit down counter (load/enable/zero interface) among NREQ requesters.
//  Grants one requester at a time; loads the counter with SLOT, decrements it, and releases the grant when the counter reaches zero.
//  Sits between requesting blocks and the shared counter; the counter is external and driven only by this block.
// PARAMETERS
//  NREQ   4      number of requesters, 2..8
//  SLOT   2'd3   value loaded into counter per grant, 0..3
//  IDW    2      width of gnt_id, must equal $clog2(NREQ)
// PORTS
//  clk         in   1     rising-edge clock
//  reset       in   1     asynchronous, active-high reset
//  req         in   NREQ  request per requester, level-sensitive
//  gnt         out  NREQ  one-hot grant, registered
//  gnt_id      out  IDW   index of current owner, valid when busy=1
//  busy        out  1     a grant is active
//  cnt_load    out  1     to counter load
//  cnt_data    out  2     to counter data, always SLOT
//  cnt_enable  out  1     to counter enable
//  cnt_zero    in   1     from counter zero flag
// BEHAVIOUR
//  - One clock (clk); reset is asynchronous and active-high. Reset: state=IDLE, gnt=0, gnt_id=0, busy=0, rr pointer=NREQ-1 (req[0] wins first).
//  - States: IDLE, LOAD, RUN. Decode of state drives cnt_load (LOAD only) and cnt_enable (RUN & ~cnt_zero); no other state touches the counter.
//  - IDLE: if |req, select winner round-robin: first set req[i] scanning from ptr+1 upward with wrap; gnt<=onehot(i), gnt_id<=i, ptr<=i, busy<=1, -> LOAD. Else stay.
//  - LOAD: cnt_load=1 for exactly one cycle -> RUN. Counter holds SLOT on entry to RUN.
//  - RUN: cnt_enable=1 while cnt_zero=0. Release when cnt_zero=1 sampled in RUN.
//  - Grant length: SLOT+2 cycles (1 LOAD + SLOT+1 RUN). SLOT=0 gives 2 cycles. Enable never asserted while cnt_zero=1, so counter never wraps 0->3.
//  - On release: if any req (including the releasing owner) is set, arbitrate in the same cycle from ptr+1 and go directly to LOAD (no idle bubble); owner is re-granted only if no other req is set. Else gnt<=0, busy<=0, -> IDLE.
//  - Requests arriving during a grant wait; req is not latched — a req dropped before arbitration is lost.
//  - cnt_zero is ignored in IDLE and LOAD (counter contents before first load are don't-care).
//  - gnt is always one-hot or zero; gnt_id holds last owner while busy=0.
//  - Reset asserted mid-grant: gnt drops immediately (async), counter left as is; next grant reloads it.
// CONFIGURATION
//  - SLOT_ARB_EARLY_REL_EN defined: in RUN, if req[gnt_id]=0 the grant releases at that edge (same release path as cnt_zero, incl. re-arbitration); in LOAD, owner drop releases at end of LOAD.
//  - Not defined: grant held for full SLOT+2 cycles regardless of owner req.
// TESTING
//  - Reset with req=4'b1111, release reset -> gnt=0001 for 5 cycles (SLOT=3), then 0010, 0100, 1000, 0001 each 5 cycles, no gap.
//  - Single req[2] held high continuously -> gnt=0100 re-granted back-to-back, cnt_load pulses every 5 cycles, cnt_enable low in each LOAD and zero cycle.
//  - req=0001 pulsed 1 cycle in IDLE -> gnt=0001 next edge, held 5 cycles, busy then 0, state IDLE.
//  - SLOT=0, req=0011 -> alternating 0001/0010 each 2 cycles; counter never observed at 3 after load.
//  - req[1] granted, reset asserted in RUN -> gnt=0, busy=0 same cycle without clk edge; after release req[0] and req[1] high -> req[0] granted first.
//  - With SLOT_ARB_EARLY_REL_EN: req[3] owner drops in 2nd RUN cycle, req[0] pending -> gnt=0001 next edge; without macro gnt=1000 held full 5 cycles.

Source files
------------

// File: rtl/slot_arbiter_dc_if.sv
// ----------------------------------------------------------------------------
// slot_arbiter_dc_if
// Purpose : bundles the requester bus and the shared 2-bit down-counter
//           interface of slot_arbiter_dc.
// Signals : req        requester -> arbiter, one level-sensitive bit each
//           gnt        arbiter -> requesters, one-hot grant (or zero)
//           gnt_id     arbiter -> requesters, index of the current owner
//           busy       arbiter -> requesters, a grant is active
//           cnt_load   arbiter -> counter, load strobe
//           cnt_data   arbiter -> counter, load value (always SLOT)
//           cnt_enable arbiter -> counter, decrement enable
//           cnt_zero   counter -> arbiter, counter is zero
// Modports: master = arbiter side, slave = requesters plus counter side.
// ----------------------------------------------------------------------------
interface slot_arbiter_dc_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
);
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_id;
   logic            busy;
   logic            cnt_load;
   logic [1:0]      cnt_data;
   logic            cnt_enable;
   logic            cnt_zero;

   modport master (
      input  req,
      input  cnt_zero,
      output gnt,
      output gnt_id,
      output busy,
      output cnt_load,
      output cnt_data,
      output cnt_enable
   );

   modport slave (
      output req,
      output cnt_zero,
      input  gnt,
      input  gnt_id,
      input  busy,
      input  cnt_load,
      input  cnt_data,
      input  cnt_enable
   );
endinterface

// File: rtl/slot_arbiter_dc.sv
// ----------------------------------------------------------------------------
// slot_arbiter_dc
// Purpose : time-slot round-robin arbiter sharing one external 2-bit down
//           counter among NREQ requesters. Each grant loads the counter with
//           SLOT, counts it down and releases when the counter reads zero,
//           giving a grant length of SLOT+2 cycles (1 LOAD + SLOT+1 RUN).
//           On release it re-arbitrates in the same cycle (no idle bubble).
// Ports   : clk    rising-edge clock
//           reset  asynchronous, active-high reset
//           bus    slot_arbiter_dc_if.master (req/gnt/gnt_id/busy and the
//                  cnt_load/cnt_data/cnt_enable/cnt_zero counter interface)
// Parameters: NREQ (2..8), SLOT (0..3), IDW (= $clog2(NREQ))
// Option  : define SLOT_ARB_EARLY_REL_EN to release a grant as soon as its
//           owner drops req (in RUN at that edge, in LOAD at end of LOAD).
//           Without it the grant is held for the full SLOT+2 cycles.
// ----------------------------------------------------------------------------
module slot_arbiter_dc #(
   parameter int unsigned NREQ = 4,
   parameter logic [1:0]  SLOT = 2'd3,
   parameter int unsigned IDW  = 2
) (
   input logic               clk,
   input logic               reset,
   slot_arbiter_dc_if.master bus
);

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StRun
   } state_e;

   state_e          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [IDW-1:0]  gnt_id_q, gnt_id_d;
   logic            busy_q, busy_d;
   logic [IDW-1:0]  ptr_q, ptr_d;

   logic            win_found;
   logic [IDW-1:0]  win_id;
   logic            do_arb;

`ifdef SLOT_ARB_EARLY_REL_EN
   logic owner_req;
   assign owner_req = bus.req[gnt_id_q];
`endif

   // Round-robin pick: first set req scanning upward from ptr+1 with wrap.
   // The previous owner is scanned last, so it only wins when it is alone.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         int unsigned idx;
         idx = (32'(ptr_q) + k) % NREQ;
         if (!win_found && bus.req[idx]) begin
            win_found = 1'b1;
            win_id    = IDW'(idx);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      busy_d   = busy_q;
      ptr_d    = ptr_q;
      do_arb   = 1'b0;

      case (state_q)
         StIdle: begin
            do_arb = 1'b1;
         end
         StLoad: begin
            state_d = StRun;
`ifdef SLOT_ARB_EARLY_REL_EN
            if (!owner_req) begin
               do_arb = 1'b1;
            end
`endif
         end
         StRun: begin
            // cnt_zero is only meaningful here; the counter holds SLOT on entry.
            if (bus.cnt_zero) begin
               do_arb = 1'b1;
            end
`ifdef SLOT_ARB_EARLY_REL_EN
            if (!owner_req) begin
               do_arb = 1'b1;
            end
`endif
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Shared by first grant from IDLE and by every release path.
      if (do_arb) begin
         if (win_found) begin
            gnt_d         = '0;
            gnt_d[win_id] = 1'b1;
            gnt_id_d      = win_id;
            ptr_d         = win_id;
            busy_d        = 1'b1;
            state_d       = StLoad;
         end else begin
            gnt_d   = '0;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         busy_q   <= 1'b0;
         ptr_q    <= IDW'(NREQ - 1);
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         busy_q   <= busy_d;
         ptr_q    <= ptr_d;
      end
   end

   assign bus.gnt        = gnt_q;
   assign bus.gnt_id     = gnt_id_q;
   assign bus.busy       = busy_q;
   assign bus.cnt_data   = SLOT;
   assign bus.cnt_load   = (state_q == StLoad);
   // Never enable at zero, so the counter cannot wrap 0 -> 3.
   assign bus.cnt_enable = (state_q == StRun) && !bus.cnt_zero;

endmodule

// File: tb/tb_slot_arbiter_dc.sv
// ----------------------------------------------------------------------------
// tb_slot_arbiter_dc
// Scoreboard bench for slot_arbiter_dc. Stimulus pushes the expected grants
// (one-hot gnt, gnt_id, length in cycles) into a queue; a monitor cuts the
// DUT activity into grants (each begins with a cnt_load cycle) and pops and
// compares. dut_a runs SLOT=3, dut_b runs SLOT=0 with req=0011 held.
// ----------------------------------------------------------------------------
module tb_slot_arbiter_dc;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   slot_arbiter_dc_if #(.NREQ(4), .IDW(2)) bus_a ();
   slot_arbiter_dc_if #(.NREQ(4), .IDW(2)) bus_b ();

   slot_arbiter_dc #(.NREQ(4), .SLOT(2'd3), .IDW(2)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   slot_arbiter_dc #(.NREQ(4), .SLOT(2'd0), .IDW(2)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   // External 2-bit down counters; not reset by the arbiter reset.
   logic [1:0] cnt_a = 2'd0;
   logic [1:0] cnt_b = 2'd0;

   always @(posedge clk) begin
      if (bus_a.cnt_load) cnt_a <= bus_a.cnt_data;
      else if (bus_a.cnt_enable) cnt_a <= cnt_a - 2'd1;
      if (bus_b.cnt_load) cnt_b <= bus_b.cnt_data;
      else if (bus_b.cnt_enable) cnt_b <= cnt_b - 2'd1;
   end

   assign bus_a.cnt_zero = (cnt_a == 2'd0);
   assign bus_b.cnt_zero = (cnt_b == 2'd0);

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] id;
      logic [7:0] len;
   } grant_t;

   grant_t exp_q[$];
   int     errors = 0;
   int     checks = 0;
   int     viol   = 0;
   time    viol_t = 0;

`ifdef SLOT_ARB_EARLY_REL_EN
   localparam int EarlyRel = 1;
`else
   localparam int EarlyRel = 0;
`endif

   task automatic push(input logic [3:0] g, input logic [1:0] id, input int len);
      exp_q.push_back('{gnt: g, id: id, len: 8'(len)});
   endtask

   // ---------------- monitor ----------------
   logic       mon_open = 1'b0;
   logic [3:0] cur_gnt;
   logic [1:0] cur_id;
   int         cur_len;

   task automatic close_grant();
      grant_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL grant_unexpected: got gnt=%b id=%0d len=%0d, required none",
                  cur_gnt, cur_id, cur_len);
      end else begin
         e = exp_q.pop_front();
         if (e.gnt !== cur_gnt || e.id !== cur_id || int'(e.len) != cur_len) begin
            errors++;
            $display("FAIL grant: got gnt=%b id=%0d len=%0d, required gnt=%b id=%0d len=%0d",
                     cur_gnt, cur_id, cur_len, e.gnt, e.id, e.len);
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            mon_open = 1'b0;
         end else begin
            if (bus_a.cnt_load) begin
               if (mon_open) close_grant();
               mon_open = 1'b1;
               cur_gnt  = bus_a.gnt;
               cur_id   = bus_a.gnt_id;
               cur_len  = 1;
            end else if (mon_open) begin
               if (bus_a.busy) begin
                  cur_len++;
                  if (bus_a.gnt !== cur_gnt) begin
                     viol++;
                     viol_t = $time;
                  end
               end else begin
                  close_grant();
                  mon_open = 1'b0;
               end
            end
            // Structural invariants: one-hot grant matching gnt_id, no enable at zero/load.
            if ((bus_a.gnt & (bus_a.gnt - 4'd1)) != 4'd0 ||
                (bus_a.busy && bus_a.gnt !== (4'b0001 << bus_a.gnt_id)) ||
                (!bus_a.busy && bus_a.gnt !== 4'b0000) ||
                (bus_a.cnt_enable && (bus_a.cnt_zero || bus_a.cnt_load))) begin
               viol++;
               viol_t = $time;
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic wait_loads(input int n);
      int seen = 0;
      int cyc  = 0;
      while (seen < n && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (bus_a.cnt_load) seen++;
      end
      if (seen < n) begin
         checks++;
         errors++;
         $display("FAIL load_timeout: got %0d loads, required %0d", seen, n);
      end
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req_v);
      checks++;
      if (act !== req_v) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req_v);
      end
   endtask

   // ---------------- SLOT=0 instance: alternating 2-cycle grants ----------------
   initial begin
      int cyc;
      logic [3:0] exp_g;
      bus_b.req = 4'b0011;
      @(negedge reset);
      cyc = 0;
      while (!bus_b.cnt_load && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      for (int k = 0; k < 8; k++) begin
         exp_g = ((k / 2) % 2 == 0) ? 4'b0001 : 4'b0010;
         checks++;
         if (bus_b.gnt !== exp_g || !bus_b.busy || cnt_b == 2'd3) begin
            errors++;
            $display("FAIL slot0_step%0d: got gnt=%b busy=%b cnt=%0d, required gnt=%b busy=1 cnt!=3",
                     k, bus_b.gnt, bus_b.busy, cnt_b, exp_g);
         end
         @(negedge clk);
      end
   end

   // ---------------- main stimulus ----------------
   initial begin
      reset     = 1'b1;
      bus_a.req = 4'b1111;
      #1;
      check("reset_gnt", 8'(bus_a.gnt), 8'h0);
      check("reset_busy", 8'(bus_a.busy), 8'h0);
      repeat (2) @(negedge clk);

      // All requesting: rotate 0,1,2,3,0 with 5-cycle grants and no gap.
      push(4'b0001, 2'd0, 5);
      push(4'b0010, 2'd1, 5);
      push(4'b0100, 2'd2, 5);
      push(4'b1000, 2'd3, 5);
      push(4'b0001, 2'd0, 5);
      reset = 1'b0;
      wait_loads(5);
      repeat (4) @(negedge clk);
      bus_a.req = 4'b0000;
      repeat (2) @(negedge clk);

      // Lone requester re-granted back to back.
      push(4'b0100, 2'd2, 5);
      push(4'b0100, 2'd2, 5);
      push(4'b0100, 2'd2, 5);
      bus_a.req = 4'b0100;
      wait_loads(3);
      repeat (4) @(negedge clk);
      bus_a.req = 4'b0000;
      repeat (2) @(negedge clk);
      check("idle_busy", 8'(bus_a.busy), 8'h0);
      check("idle_gnt_id_held", 8'(bus_a.gnt_id), 8'h2);

      // One-cycle pulse from IDLE.
      push(4'b0001, 2'd0, EarlyRel ? 1 : 5);
      bus_a.req = 4'b0001;
      @(negedge clk);
      bus_a.req = 4'b0000;
      repeat (7) @(negedge clk);
      check("pulse_busy", 8'(bus_a.busy), 8'h0);
      check("pulse_gnt", 8'(bus_a.gnt), 8'h0);

      // Reset in the middle of a RUN.
      bus_a.req = 4'b0010;
      wait_loads(1);
      repeat (2) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_gnt", 8'(bus_a.gnt), 8'h0);
      check("async_rst_busy", 8'(bus_a.busy), 8'h0);
      @(negedge clk);
      bus_a.req = 4'b0011;
      push(4'b0001, 2'd0, 5);
      push(4'b0010, 2'd1, 5);
      @(negedge clk);
      reset = 1'b0;
      wait_loads(2);
      repeat (4) @(negedge clk);
      bus_a.req = 4'b0000;
      repeat (2) @(negedge clk);

      // Owner 3 drops req in its 2nd RUN cycle while req 0 waits.
      push(4'b1000, 2'd3, EarlyRel ? 3 : 5);
      push(4'b0001, 2'd0, 5);
      bus_a.req = 4'b1000;
      wait_loads(1);
      bus_a.req = 4'b1001;
      repeat (2) @(negedge clk);
      bus_a.req = 4'b0001;
      wait_loads(1);
      repeat (4) @(negedge clk);
      bus_a.req = 4'b0000;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending grants, required 0", exp_q.size());
      end
      checks++;
      if (viol != 0) begin
         errors++;
         $display("FAIL invariants: got %0d violations (first at %0t), required 0", viol, viol_t);
      end
      check("final_busy", 8'(bus_a.busy), 8'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
